sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 129 ++++++++++++
 tb/tb_sdram_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Arbitrates SDRAM burst traffic between the frame loader (writes) and the VGA
// read FIFO. One frame is written once, then read repeatedly.
module sdram_arbiter #(
    parameter int unsigned BURST_LEN    = 512,
    parameter int unsigned FRAME_BURSTS = 600,
    parameter int unsigned RD_THRESH    = 256,
    parameter int unsigned ADDR_W       = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic [9:0]        wr_fifo_level,
    input  logic [9:0]        rd_fifo_level,
    input  logic              frame_start,
    output logic              wr_sdram_req,
    input  logic              wr_sdram_ack,
    output logic              rd_sdram_req,
    input  logic              rd_sdram_ack,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              frame_loaded,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst} state_t;

    localparam logic [10:0]       BurstLenL = 11'(BURST_LEN);
    localparam logic [10:0]       RdThreshL = 11'(RD_THRESH);
    localparam logic [9:0]        LastBurst = 10'(FRAME_BURSTS - 1);
    localparam logic [ADDR_W-1:0] BurstLenA = ADDR_W'(BURST_LEN);

    state_t     state;
    logic [9:0] wr_ptr;
    logic [9:0] rd_ptr;
    logic       rd_rst_pending;

    logic       wr_go;
    logic       rd_go;
    logic       rd_restart;
    logic [9:0] wr_ptr_inc;
    logic [9:0] rd_ptr_inc;

    function automatic logic [ADDR_W-1:0] burst_addr(input logic [9:0] ptr);
        return ADDR_W'(ptr) * BurstLenA;
    endfunction

    always_comb begin
        wr_go      = !frame_loaded && ({1'b0, wr_fifo_level} >= BurstLenL);
        rd_go      = frame_loaded && !rd_rst_pending && ({1'b0, rd_fifo_level} < RdThreshL);
        // A vsync seen during the burst, or on the ack cycle itself, restarts the read frame.
        rd_restart = rd_rst_pending || frame_start;
        wr_ptr_inc = (wr_ptr == LastBurst) ? 10'd0 : wr_ptr + 10'd1;
        rd_ptr_inc = (rd_ptr == LastBurst) ? 10'd0 : rd_ptr + 10'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            rd_rst_pending <= 1'b0;
            wr_sdram_req   <= 1'b0;
            rd_sdram_req   <= 1'b0;
            sdram_addr     <= '0;
            frame_loaded   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (frame_start) begin
                        rd_ptr <= '0;
                    end else if (init_done && rd_go) begin
                        state        <= StRdBurst;
                        rd_sdram_req <= 1'b1;
                        sdram_addr   <= burst_addr(rd_ptr);
                        busy         <= 1'b1;
                    end else if (init_done && wr_go) begin
                        state        <= StWrBurst;
                        wr_sdram_req <= 1'b1;
                        sdram_addr   <= burst_addr(wr_ptr);
                        busy         <= 1'b1;
                    end
                end
                StWrBurst: begin
                    if (frame_start) begin
                        rd_rst_pending <= 1'b1;
                    end
                    if (wr_sdram_ack) begin
                        state        <= StIdle;
                        wr_sdram_req <= 1'b0;
                        busy         <= 1'b0;
                        wr_ptr       <= wr_ptr_inc;
                        if (wr_ptr == LastBurst) begin
                            frame_loaded <= 1'b1;
                        end
                        if (rd_restart) begin
                            rd_ptr         <= '0;
                            rd_rst_pending <= 1'b0;
                        end
                    end
                end
                StRdBurst: begin
                    if (frame_start) begin
                        rd_rst_pending <= 1'b1;
                    end
                    if (rd_sdram_ack) begin
                        state          <= StIdle;
                        rd_sdram_req   <= 1'b0;
                        busy           <= 1'b0;
                        rd_ptr         <= rd_restart ? 10'd0 : rd_ptr_inc;
                        rd_rst_pending <= 1'b0;
                    end
                end
                default: begin
                    state        <= StIdle;
                    wr_sdram_req <= 1'b0;
                    rd_sdram_req <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    a_req_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_sdram_req && rd_sdram_req));

    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy == (state != StIdle));

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: vector table for the basic write path, then
// hand-written burst sequences for frame load, read wrap, vsync and reset cases.
module tb_sdram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic [9:0]  wr_fifo_level;
    logic [9:0]  rd_fifo_level;
    logic        frame_start;
    logic        wr_sdram_req;
    logic        wr_sdram_ack;
    logic        rd_sdram_req;
    logic        rd_sdram_ack;
    logic [21:0] sdram_addr;
    logic        frame_loaded;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    sdram_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_done     (init_done),
        .wr_fifo_level (wr_fifo_level),
        .rd_fifo_level (rd_fifo_level),
        .frame_start   (frame_start),
        .wr_sdram_req  (wr_sdram_req),
        .wr_sdram_ack  (wr_sdram_ack),
        .rd_sdram_req  (rd_sdram_req),
        .rd_sdram_ack  (rd_sdram_ack),
        .sdram_addr    (sdram_addr),
        .frame_loaded  (frame_loaded),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        init;
        logic [9:0]  wr_lvl;
        logic        fs;
        logic        wack;
        logic        rack;
        logic        e_wr;
        logic        e_rd;
        logic [21:0] e_addr;
        logic        e_busy;
        logic        e_loaded;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ew, input logic er,
                         input logic [21:0] ea, input logic eb, input logic el);
        n_vec++;
        if ({wr_sdram_req, rd_sdram_req, sdram_addr, busy, frame_loaded} !== {ew, er, ea, eb, el}
            || (wr_sdram_req && rd_sdram_req)) begin
            n_err++;
            $display("FAIL %s: got wr=%b rd=%b addr=%0d busy=%b loaded=%b, want wr=%b rd=%b addr=%0d busy=%b loaded=%b",
                     name, wr_sdram_req, rd_sdram_req, sdram_addr, busy, frame_loaded,
                     ew, er, ea, eb, el);
        end
    endtask

    task automatic wr_burst(input int idx, input logic loaded_after);
        logic [21:0] a;
        a = 22'(idx * 512);
        wr_fifo_level = 10'd512;
        step();
        check($sformatf("wr_req[%0d]", idx), 1'b1, 1'b0, a, 1'b1, 1'b0);
        wr_sdram_ack = 1'b1;
        step();
        wr_sdram_ack = 1'b0;
        check($sformatf("wr_ack[%0d]", idx), 1'b0, 1'b0, a, 1'b0, loaded_after);
    endtask

    // Write FIFO kept full so any write request would be visible alongside the read.
    task automatic rd_burst(input int idx, input logic fs_mid);
        logic [21:0] a;
        a = 22'(idx * 512);
        rd_fifo_level = 10'd100;
        wr_fifo_level = 10'd512;
        step();
        check($sformatf("rd_req[%0d]", idx), 1'b0, 1'b1, a, 1'b1, 1'b1);
        if (fs_mid) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            check($sformatf("rd_fs_hold[%0d]", idx), 1'b0, 1'b1, a, 1'b1, 1'b1);
        end
        rd_sdram_ack = 1'b1;
        step();
        rd_sdram_ack = 1'b0;
        check($sformatf("rd_ack[%0d]", idx), 1'b0, 1'b0, a, 1'b0, 1'b1);
    endtask

    initial begin
        //                init wr_lvl   fs    wack  rack  e_wr  e_rd  e_addr      busy  loaded
        vecs[0]  = '{1'b0, 10'd512, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 22'd0,    1'b0, 1'b0};
        vecs[1]  = '{1'b1, 10'd511, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 22'd0,    1'b0, 1'b0};
        vecs[2]  = '{1'b1, 10'd512, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 22'd0,    1'b1, 1'b0};
        vecs[3]  = '{1'b1, 10'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 22'd0,    1'b1, 1'b0};
        vecs[4]  = '{1'b1, 10'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 22'd0,    1'b1, 1'b0};
        vecs[5]  = '{1'b1, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 22'd0,    1'b0, 1'b0};
        vecs[6]  = '{1'b1, 10'd512, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 22'd512,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 22'd512,  1'b0, 1'b0};
        vecs[8]  = '{1'b1, 10'd512, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'd512,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 10'd512, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 22'd1024, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 10'd512, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 22'd1024, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 10'd512, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 22'd1024, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 10'd512, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 22'd1024, 1'b0, 1'b0};

        rst_n         = 1'b0;
        init_done     = 1'b0;
        wr_fifo_level = 10'd0;
        rd_fifo_level = 10'd300;
        frame_start   = 1'b0;
        wr_sdram_ack  = 1'b0;
        rd_sdram_ack  = 1'b0;
        step();
        step();
        check("reset", 1'b0, 1'b0, 22'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            init_done     = vecs[i].init;
            wr_fifo_level = vecs[i].wr_lvl;
            frame_start   = vecs[i].fs;
            wr_sdram_ack  = vecs[i].wack;
            rd_sdram_ack  = vecs[i].rack;
            step();
            check($sformatf("vec[%0d]", i), vecs[i].e_wr, vecs[i].e_rd, vecs[i].e_addr,
                  vecs[i].e_busy, vecs[i].e_loaded);
        end
        frame_start  = 1'b0;
        wr_sdram_ack = 1'b0;
        rd_sdram_ack = 1'b0;

        // Finish the frame: bursts 3..599, frame_loaded rises on the 600th ack.
        init_done = 1'b1;
        for (int i = 3; i < 600; i++) begin
            wr_burst(i, i == 599);
        end

        wr_fifo_level = 10'd512;
        rd_fifo_level = 10'd300;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("no_wr_after_load[%0d]", i), 1'b0, 1'b0, 22'(599 * 512), 1'b0, 1'b1);
        end

        // Reads up to rd_ptr=37, vsync mid-burst there, then back to 0.
        for (int i = 0; i < 37; i++) begin
            rd_burst(i, 1'b0);
        end
        rd_burst(37, 1'b1);
        for (int i = 0; i < 600; i++) begin
            rd_burst(i, 1'b0);
        end
        rd_burst(0, 1'b0);

        // init_done drops mid-burst: burst completes, nothing new is issued.
        rd_fifo_level = 10'd100;
        step();
        check("initfall_req", 1'b0, 1'b1, 22'd512, 1'b1, 1'b1);
        init_done = 1'b0;
        step();
        check("initfall_hold", 1'b0, 1'b1, 22'd512, 1'b1, 1'b1);
        rd_sdram_ack = 1'b1;
        step();
        rd_sdram_ack = 1'b0;
        check("initfall_ack", 1'b0, 1'b0, 22'd512, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("initfall_idle[%0d]", i), 1'b0, 1'b0, 22'd512, 1'b0, 1'b1);
        end

        // Clear frame_loaded, then reset asynchronously in the middle of a write burst.
        rst_n = 1'b0;
        #2;
        check("rst_clear", 1'b0, 1'b0, 22'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n         = 1'b1;
        init_done     = 1'b1;
        rd_fifo_level = 10'd300;
        wr_burst(0, 1'b0);
        step();
        check("rst_mid_req", 1'b1, 1'b0, 22'd512, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 1'b0, 1'b0, 22'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_restart", 1'b1, 1'b0, 22'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
